trap_ctrl: RTL and testbench
============================

// Module: trap_ctrl
// PURPOSE
//   Trap sequencer for the machine-mode CSR file. Arbitrates synchronous exceptions, mret and
//   pending interrupts at the writeback stage. Drives the CSR file side-effect strobes
//   (mcause/mepc write, mstatus MIE clear/set). Issues pipeline hold, flush and PC redirect
//   to the trap vector or to mepc.
// PARAMETERS
//   DATA_WIDTH   32  data/PC width
//   VECTORED_EN  1   1: honour mtvec MODE=01 (interrupts go to BASE+4*cause); 0: always BASE
// PORTS
//   clk_i                input   1           clock
//   rst_ni               input   1           reset, asynchronous, active-low
//   instr_valid_i        input   1           WB holds a valid instruction boundary (interrupt may be taken)
//   exception_i          input   1           WB instruction raises synchronous exception
//   exc_cause_i          input   4           exception code (2 illegal, 3 ebreak, 11 ecall-M)
//   exc_pc_i             input   DATA_WIDTH  PC of faulting instruction
//   mret_i               input   1           WB instruction is mret
//   next_pc_i            input   DATA_WIDTH  PC of next unexecuted instruction (interrupt mepc)
//   mstatus_ie_i         input   1           mstatus.MIE from CSR file
//   mie_external_i/mie_timer_i/mie_software_i  input 1 each  interrupt enables
//   mip_external_i/mip_timer_i/mip_software_i  input 1 each  interrupt pending
//   mtvec_i              input   DATA_WIDTH  trap vector CSR
//   epc_i                input   DATA_WIDTH  mepc CSR
//   ack_o                output  1           comb: event accepted this cycle; WB suppresses commit of excepting instr
//   hold_o               output  1           pipeline stall, high while FSM not IDLE
//   interrupt_type_o     output  1           to CSR file: mcause[31]
//   cause_we_o           output  1           to CSR file: mcause write strobe
//   cause_o              output  4           to CSR file: mcause code
//   epc_we_o             output  1           to CSR file: mepc write strobe
//   epc_o                output  DATA_WIDTH  to CSR file: mepc value
//   mstatus_ie_clear_o   output  1           to CSR file: MPIE<=MIE, MIE<=0
//   mstatus_ie_set_o     output  1           to CSR file: MIE<=MPIE, MPIE<=1
//   flush_o              output  1           flush IF..EX
//   redirect_o           output  1           load PC with redirect_pc_o
//   redirect_pc_o        output  DATA_WIDTH  new PC
// BEHAVIOUR
//   - States: IDLE, TRAP, MRET, JUMP. On reset: state=IDLE, all outputs and latched cause/pc/target = 0.
//     Reset asserted mid-sequence aborts immediately; no strobe completes.
//   - irq = mstatus_ie_i & |(mie_x_i & mip_x_i). Interrupt priority: external (11) > software (3) > timer (7).
//   - IDLE event priority: exception_i > mret_i > (irq & instr_valid_i). ack_o = IDLE & any accepted event.
//     Exception_i/mret_i do not require instr_valid_i.
//   - Accept exception: latch cause=exc_cause_i, type=0, pc=exc_pc_i, target=BASE -> TRAP.
//   - Accept irq: latch cause=code, type=1, pc=next_pc_i, target=BASE+{cause,2'b00} if VECTORED_EN &&
//     mtvec_i[1:0]==2'b01, else BASE -> TRAP. BASE={mtvec_i[DW-1:2],2'b00}; add wraps modulo 2^DW.
//     mtvec_i is sampled at acceptance.
//   - Accept mret: latch target={epc_i[DW-1:2],2'b00} -> MRET.
//   - TRAP (1 cycle): cause_we_o=epc_we_o=mstatus_ie_clear_o=1; cause_o/interrupt_type_o/epc_o = latched. -> JUMP.
//   - MRET (1 cycle): mstatus_ie_set_o=1. -> JUMP.
//   - JUMP (1 cycle): redirect_o=flush_o=1, redirect_pc_o=target. -> IDLE.
//   - All strobes are registered (decoded from state flops); each pulses exactly one cycle per event.
//   - Strobe values outside the active state are 0. epc_o/cause_o hold their last latched value.
//   - hold_o=1 in TRAP/MRET/JUMP; inputs are ignored outside IDLE. Latency event->redirect = 2 cycles.
//   - After JUMP from MRET, an irq enabled by the restored MIE may be accepted in the very next IDLE cycle.
//   - Irq deasserting after acceptance does not cancel the sequence.
// TESTING
//   1 ecall: exception_i, cause 11, exc_pc 0x100, mtvec 0x200 -> TRAP: cause_o=11, type 0, epc_o=0x100,
//     ie_clear=1; JUMP: redirect_pc 0x200, flush=1.
//   2 vectored timer: mtvec 0x201, MIE=1, mie/mip_timer=1, next_pc 0x40 -> cause 7, type 1, epc 0x40,
//     redirect 0x21C.
//   3 priority: ext+sw+timer pending together -> cause 11 type 1; exception(2) with irq same cycle ->
//     cause 2 type 0.
//   4 mret: epc_i 0x44 -> MRET: ie_set=1 one cycle; JUMP: redirect 0x44; no cause/epc strobe.
//   5 masking: MIE=0 with pending irq -> no ack for 20 cycles; MIE=1 with instr_valid_i=0 -> waits,
//     taken the cycle instr_valid_i=1.
//   6 rst_ni low during TRAP -> all outputs 0 asynchronously; after release, IDLE with no redirect.

Source files
------------

// File: rtl/trap_ctrl_if.sv
//------------------------------------------------------------------------------
// trap_ctrl_if
// Purpose : Bundles the writeback-stage event inputs, the CSR-file status
//           inputs and the sequencer's CSR strobes and pipeline controls.
//           Signal names follow the trap_ctrl port list.
// Modports: slave  - the trap sequencer (consumes events and CSR state,
//                    drives strobes and pipeline controls)
//           master - the pipeline/CSR-file side (the opposite view)
//------------------------------------------------------------------------------
`timescale 1ns/1ps
interface trap_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  instr_valid_i;
    logic                  exception_i;
    logic [3:0]            exc_cause_i;
    logic [DATA_WIDTH-1:0] exc_pc_i;
    logic                  mret_i;
    logic [DATA_WIDTH-1:0] next_pc_i;
    logic                  mstatus_ie_i;
    logic                  mie_external_i;
    logic                  mie_timer_i;
    logic                  mie_software_i;
    logic                  mip_external_i;
    logic                  mip_timer_i;
    logic                  mip_software_i;
    logic [DATA_WIDTH-1:0] mtvec_i;
    logic [DATA_WIDTH-1:0] epc_i;

    logic                  ack_o;
    logic                  hold_o;
    logic                  interrupt_type_o;
    logic                  cause_we_o;
    logic [3:0]            cause_o;
    logic                  epc_we_o;
    logic [DATA_WIDTH-1:0] epc_o;
    logic                  mstatus_ie_clear_o;
    logic                  mstatus_ie_set_o;
    logic                  flush_o;
    logic                  redirect_o;
    logic [DATA_WIDTH-1:0] redirect_pc_o;

    modport slave (
        input  instr_valid_i, exception_i, exc_cause_i, exc_pc_i, mret_i, next_pc_i,
               mstatus_ie_i, mie_external_i, mie_timer_i, mie_software_i,
               mip_external_i, mip_timer_i, mip_software_i, mtvec_i, epc_i,
        output ack_o, hold_o, interrupt_type_o, cause_we_o, cause_o, epc_we_o, epc_o,
               mstatus_ie_clear_o, mstatus_ie_set_o, flush_o, redirect_o, redirect_pc_o
    );

    modport master (
        output instr_valid_i, exception_i, exc_cause_i, exc_pc_i, mret_i, next_pc_i,
               mstatus_ie_i, mie_external_i, mie_timer_i, mie_software_i,
               mip_external_i, mip_timer_i, mip_software_i, mtvec_i, epc_i,
        input  ack_o, hold_o, interrupt_type_o, cause_we_o, cause_o, epc_we_o, epc_o,
               mstatus_ie_clear_o, mstatus_ie_set_o, flush_o, redirect_o, redirect_pc_o
    );
endinterface

// File: rtl/trap_ctrl.sv
//------------------------------------------------------------------------------
// trap_ctrl
// Purpose : Machine-mode trap sequencer. In IDLE it arbitrates a synchronous
//           exception, an mret and a pending enabled interrupt (in that
//           priority order), latches cause / mepc / redirect target, then
//           walks TRAP or MRET (CSR side-effect strobes) and JUMP (flush and
//           PC redirect) before returning to IDLE. Pipeline is held while
//           the sequence runs.
// Ports   : clk_i   - clock
//           rst_ni  - asynchronous active-low reset
//           bus     - trap_ctrl_if.slave: WB events, CSR state in;
//                     CSR strobes, hold/flush/redirect out
// Params  : DATA_WIDTH  - PC/data width
//           VECTORED_EN - honour mtvec MODE=01 for interrupts
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module trap_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    trap_ctrl_if.slave    bus
);
    localparam int DW = DATA_WIDTH;
    localparam logic [DW-1:0] ALIGN_MASK = {{(DW-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {IDLE, TRAP, MRET, JUMP} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cause_q;
    logic          type_q;
    logic [DW-1:0] pc_q;
    logic [DW-1:0] target_q;

    logic          irq_ext, irq_sw, irq_tmr, irq;
    logic [3:0]    irq_cause;
    logic          take_exc, take_mret, take_irq;
    logic [DW-1:0] base;
    logic [DW-1:0] irq_target;

    // Interrupt qualification and fixed priority: external > software > timer
    assign irq_ext = bus.mie_external_i & bus.mip_external_i;
    assign irq_sw  = bus.mie_software_i & bus.mip_software_i;
    assign irq_tmr = bus.mie_timer_i    & bus.mip_timer_i;
    assign irq     = bus.mstatus_ie_i & (irq_ext | irq_sw | irq_tmr);

    always_comb begin
        irq_cause = 4'd7;
        if (irq_ext)     irq_cause = 4'd11;
        else if (irq_sw) irq_cause = 4'd3;
    end

    // Event arbitration; only IDLE looks at the inputs at all
    assign take_exc  = (state_q == IDLE) & bus.exception_i;
    assign take_mret = (state_q == IDLE) & ~bus.exception_i & bus.mret_i;
    assign take_irq  = (state_q == IDLE) & ~bus.exception_i & ~bus.mret_i
                       & irq & bus.instr_valid_i;

    // Vectored offset is cause*4; the add deliberately wraps at 2^DW
    assign base = bus.mtvec_i & ALIGN_MASK;
    always_comb begin
        irq_target = base;
        if (VECTORED_EN && (bus.mtvec_i[1:0] == 2'b01))
            irq_target = base + {{(DW-6){1'b0}}, irq_cause, 2'b00};
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take_exc || take_irq) state_d = TRAP;
                else if (take_mret)       state_d = MRET;
            end
            TRAP:    state_d = JUMP;
            MRET:    state_d = JUMP;
            JUMP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Event context captured at acceptance; mret only replaces the target
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cause_q  <= '0;
            type_q   <= 1'b0;
            pc_q     <= '0;
            target_q <= '0;
        end else if (take_exc) begin
            cause_q  <= bus.exc_cause_i;
            type_q   <= 1'b0;
            pc_q     <= bus.exc_pc_i;
            target_q <= base;
        end else if (take_irq) begin
            cause_q  <= irq_cause;
            type_q   <= 1'b1;
            pc_q     <= bus.next_pc_i;
            target_q <= irq_target;
        end else if (take_mret) begin
            target_q <= bus.epc_i & ALIGN_MASK;
        end
    end

    // Outputs: strobes decode straight from the state flop so each is
    // glitch-free and lasts exactly one cycle. ack is the only combinational
    // output and is forced low while reset is asserted.
    always_comb begin
        bus.ack_o              = rst_ni & (take_exc | take_mret | take_irq);
        bus.hold_o             = 1'b0;
        bus.interrupt_type_o   = type_q;
        bus.cause_we_o         = 1'b0;
        bus.cause_o            = cause_q;
        bus.epc_we_o           = 1'b0;
        bus.epc_o              = pc_q;
        bus.mstatus_ie_clear_o = 1'b0;
        bus.mstatus_ie_set_o   = 1'b0;
        bus.flush_o            = 1'b0;
        bus.redirect_o         = 1'b0;
        bus.redirect_pc_o      = '0;
        case (state_q)
            TRAP: begin
                bus.hold_o             = 1'b1;
                bus.cause_we_o         = 1'b1;
                bus.epc_we_o           = 1'b1;
                bus.mstatus_ie_clear_o = 1'b1;
            end
            MRET: begin
                bus.hold_o           = 1'b1;
                bus.mstatus_ie_set_o = 1'b1;
            end
            JUMP: begin
                bus.hold_o        = 1'b1;
                bus.flush_o       = 1'b1;
                bus.redirect_o    = 1'b1;
                bus.redirect_pc_o = target_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_trap_ctrl.sv
`timescale 1ns/1ps
module tb_trap_ctrl;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    trap_ctrl_if #(.DATA_WIDTH(DW)) bus();

    trap_ctrl #(.DATA_WIDTH(DW), .VECTORED_EN(1'b1)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: an accepted event schedules the two following cycles
    typedef struct {
        bit          trap;
        bit          mret;
        bit          jump;
        logic [31:0] rpc;
    } step_t;

    step_t       sched[$];
    logic [3:0]  m_cause;
    bit          m_type;
    logic [31:0] m_epc;

    // Snapshot of the most recent sampled cycle
    logic        sn_ack, sn_hold, sn_type, sn_cwe, sn_ewe, sn_clr, sn_set, sn_flush, sn_redir;
    logic [3:0]  sn_cause;
    logic [31:0] sn_epc, sn_rpc;

    task automatic model_reset();
        sched.delete();
        m_cause = '0;
        m_type  = 1'b0;
        m_epc   = '0;
    endtask

    task automatic idle_inputs();
        bus.instr_valid_i  = 0; bus.exception_i = 0; bus.exc_cause_i = 0; bus.exc_pc_i = 0;
        bus.mret_i         = 0; bus.next_pc_i   = 0; bus.mstatus_ie_i = 0;
        bus.mie_external_i = 0; bus.mie_timer_i = 0; bus.mie_software_i = 0;
        bus.mip_external_i = 0; bus.mip_timer_i = 0; bus.mip_software_i = 0;
        bus.mtvec_i        = 0; bus.epc_i       = 0;
    endtask

    task automatic rand_inputs();
        int c;
        bus.exception_i    = ($urandom % 8) == 0;
        c = $urandom % 3;
        bus.exc_cause_i    = (c == 0) ? 4'd2 : (c == 1) ? 4'd3 : 4'd11;
        bus.exc_pc_i       = $urandom;
        bus.mret_i         = ($urandom % 8) == 0;
        bus.next_pc_i      = $urandom;
        bus.instr_valid_i  = $urandom % 2;
        bus.mstatus_ie_i   = ($urandom % 4) != 0;
        bus.mie_external_i = $urandom % 2; bus.mip_external_i = ($urandom % 4) == 0;
        bus.mie_timer_i    = $urandom % 2; bus.mip_timer_i    = ($urandom % 4) == 0;
        bus.mie_software_i = $urandom % 2; bus.mip_software_i = ($urandom % 4) == 0;
        bus.mtvec_i        = $urandom;
        if ($urandom % 2) bus.mtvec_i = (bus.mtvec_i & 32'hFFFF_FFFC) | 32'd1;
        bus.epc_i          = $urandom;
    endtask

    // One clock: entered at posedge+1 with inputs settled, compares at the
    // negedge, advances the model, returns at the next posedge+1.
    task automatic cyc();
        step_t       cur;
        bit          busy, irq, exp_ack;
        logic [3:0]  ic;
        logic [31:0] base, tgt;
        step_t       s1, s2;
        @(negedge clk);
        busy = sched.size() != 0;
        cur.trap = 0; cur.mret = 0; cur.jump = 0; cur.rpc = 0;
        if (busy) cur = sched[0];

        irq = bus.mstatus_ie_i && ((bus.mie_external_i && bus.mip_external_i) ||
                                   (bus.mie_software_i && bus.mip_software_i) ||
                                   (bus.mie_timer_i    && bus.mip_timer_i));
        if (bus.mie_external_i && bus.mip_external_i)      ic = 4'd11;
        else if (bus.mie_software_i && bus.mip_software_i) ic = 4'd3;
        else                                               ic = 4'd7;
        exp_ack = !busy && (bus.exception_i || bus.mret_i || (irq && bus.instr_valid_i));

        sn_ack = bus.ack_o; sn_hold = bus.hold_o; sn_type = bus.interrupt_type_o;
        sn_cwe = bus.cause_we_o; sn_ewe = bus.epc_we_o; sn_clr = bus.mstatus_ie_clear_o;
        sn_set = bus.mstatus_ie_set_o; sn_flush = bus.flush_o; sn_redir = bus.redirect_o;
        sn_cause = bus.cause_o; sn_epc = bus.epc_o; sn_rpc = bus.redirect_pc_o;

        chk("ack",      sn_ack,   exp_ack);
        chk("hold",     sn_hold,  busy);
        chk("cause_we", sn_cwe,   cur.trap);
        chk("epc_we",   sn_ewe,   cur.trap);
        chk("ie_clear", sn_clr,   cur.trap);
        chk("ie_set",   sn_set,   cur.mret);
        chk("flush",    sn_flush, cur.jump);
        chk("redirect", sn_redir, cur.jump);
        chk("redir_pc", sn_rpc,   cur.jump ? cur.rpc : 32'd0);
        chk("cause",    sn_cause, m_cause);
        chk("irq_type", sn_type,  m_type);
        chk("epc",      sn_epc,   m_epc);

        base = bus.mtvec_i & 32'hFFFF_FFFC;
        s1.trap = 0; s1.mret = 0; s1.jump = 0; s1.rpc = 0;
        s2.trap = 0; s2.mret = 0; s2.jump = 1; s2.rpc = 0;
        if (busy) begin
            void'(sched.pop_front());
        end else if (bus.exception_i) begin
            m_cause = bus.exc_cause_i; m_type = 0; m_epc = bus.exc_pc_i;
            s1.trap = 1; s2.rpc = base;
            sched.push_back(s1); sched.push_back(s2);
        end else if (bus.mret_i) begin
            s1.mret = 1; s2.rpc = bus.epc_i & 32'hFFFF_FFFC;
            sched.push_back(s1); sched.push_back(s2);
        end else if (irq && bus.instr_valid_i) begin
            tgt = base;
            if ((bus.mtvec_i % 4) == 1) tgt = base + 32'(ic) * 32'd4;
            m_cause = ic; m_type = 1; m_epc = bus.next_pc_i;
            s1.trap = 1; s2.rpc = tgt;
            sched.push_back(s1); sched.push_back(s2);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        #12;
        chk("rst_hold",     bus.hold_o,        1'b0);
        chk("rst_cause_we", bus.cause_we_o,    1'b0);
        chk("rst_redirect", bus.redirect_o,    1'b0);
        chk("rst_redir_pc", bus.redirect_pc_o, 32'd0);
        chk("rst_epc",      bus.epc_o,         32'd0);
        chk("rst_cause",    bus.cause_o,       32'd0);
        chk("rst_ack",      bus.ack_o,         1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc();

        // ecall
        bus.exception_i = 1; bus.exc_cause_i = 4'd11; bus.exc_pc_i = 32'h100; bus.mtvec_i = 32'h200;
        cyc(); chk("t1_ack", sn_ack, 1'b1);
        idle_inputs();
        cyc(); chk("t1_cause", sn_cause, 32'd11); chk("t1_type", sn_type, 1'b0);
               chk("t1_epc", sn_epc, 32'h100);    chk("t1_clr", sn_clr, 1'b1);
        cyc(); chk("t1_rpc", sn_rpc, 32'h200);    chk("t1_flush", sn_flush, 1'b1);
        cyc();

        // vectored timer interrupt
        bus.mtvec_i = 32'h201; bus.mstatus_ie_i = 1; bus.mie_timer_i = 1; bus.mip_timer_i = 1;
        bus.next_pc_i = 32'h40; bus.instr_valid_i = 1;
        cyc(); chk("t2_ack", sn_ack, 1'b1);
        idle_inputs();
        cyc(); chk("t2_cause", sn_cause, 32'd7); chk("t2_type", sn_type, 1'b1); chk("t2_epc", sn_epc, 32'h40);
        cyc(); chk("t2_rpc", sn_rpc, 32'h21C);
        cyc();

        // all three interrupts pending together
        bus.mtvec_i = 32'h200; bus.mstatus_ie_i = 1; bus.instr_valid_i = 1;
        bus.mie_external_i = 1; bus.mip_external_i = 1; bus.mie_software_i = 1; bus.mip_software_i = 1;
        bus.mie_timer_i = 1; bus.mip_timer_i = 1;
        cyc(); idle_inputs();
        cyc(); chk("t3_cause", sn_cause, 32'd11); chk("t3_type", sn_type, 1'b1);
        cyc(); cyc();

        // exception wins over a simultaneous interrupt
        bus.exception_i = 1; bus.exc_cause_i = 4'd2; bus.exc_pc_i = 32'h88;
        bus.mstatus_ie_i = 1; bus.instr_valid_i = 1; bus.mie_timer_i = 1; bus.mip_timer_i = 1;
        cyc(); idle_inputs();
        cyc(); chk("t3b_cause", sn_cause, 32'd2); chk("t3b_type", sn_type, 1'b0);
        cyc(); cyc();

        // mret
        bus.mret_i = 1; bus.epc_i = 32'h44;
        cyc(); chk("t4_ack", sn_ack, 1'b1);
        idle_inputs();
        cyc(); chk("t4_set", sn_set, 1'b1); chk("t4_cwe", sn_cwe, 1'b0); chk("t4_ewe", sn_ewe, 1'b0);
        cyc(); chk("t4_rpc", sn_rpc, 32'h44); chk("t4_set_off", sn_set, 1'b0);
        cyc();

        // mret with an interrupt waiting: taken right after the redirect
        bus.mret_i = 1; bus.epc_i = 32'h80; bus.mstatus_ie_i = 1; bus.instr_valid_i = 1;
        bus.mie_timer_i = 1; bus.mip_timer_i = 1; bus.mtvec_i = 32'h300;
        cyc(); bus.mret_i = 0;
        cyc(); cyc();
        cyc(); chk("t4b_irq_ack", sn_ack, 1'b1);
        idle_inputs();
        cyc(); chk("t4b_cause", sn_cause, 32'd7);
        cyc(); cyc();

        // masking
        bus.mstatus_ie_i = 0; bus.mie_timer_i = 1; bus.mip_timer_i = 1; bus.instr_valid_i = 1;
        for (int i = 0; i < 20; i++) begin
            cyc(); chk("t5_masked", sn_ack, 1'b0);
        end
        bus.mstatus_ie_i = 1; bus.instr_valid_i = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(); chk("t5_noinstr", sn_ack, 1'b0);
        end
        bus.instr_valid_i = 1;
        cyc(); chk("t5_taken", sn_ack, 1'b1);
        idle_inputs();
        cyc(); cyc(); cyc();

        // vector address wraps
        bus.mtvec_i = 32'hFFFF_FFFD; bus.mstatus_ie_i = 1; bus.instr_valid_i = 1;
        bus.mie_external_i = 1; bus.mip_external_i = 1;
        cyc(); idle_inputs();
        cyc(); cyc(); chk("wrap_rpc", sn_rpc, 32'h28);
        cyc();

        // reset during TRAP
        bus.exception_i = 1; bus.exc_cause_i = 4'd3; bus.exc_pc_i = 32'h500; bus.mtvec_i = 32'h600;
        cyc(); idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_cwe",   bus.cause_we_o,         1'b0);
        chk("t6_ewe",   bus.epc_we_o,           1'b0);
        chk("t6_clr",   bus.mstatus_ie_clear_o, 1'b0);
        chk("t6_hold",  bus.hold_o,             1'b0);
        chk("t6_cause", bus.cause_o,            32'd0);
        chk("t6_epc",   bus.epc_o,              32'd0);
        chk("t6_type",  bus.interrupt_type_o,   1'b0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); chk("t6_no_redirect", sn_redir, 1'b0);
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=0x0 exp=0x1");
        $fatal(1, "timeout");
    end
endmodule
